// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter with bounded per-owner bursts sharing one combinational palette ROM.
// The response (id, RGB, colour-key flag) is registered on the transfer edge.
module palette_lookup_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned IDX_W           = 7,
  parameter int unsigned BURST           = 4,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*IDX_W-1:0]   req_index_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [IDX_W-1:0]           pal_index_o,
  input  logic [3:0]                 pal_red_i,
  input  logic [3:0]                 pal_green_i,
  input  logic [3:0]                 pal_blue_i,
  output logic                       rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [11:0]                rsp_rgb_o,
  output logic                       rsp_transparent_o
);

  localparam int unsigned       IdW      = $clog2(NUM_REQ);
  localparam int unsigned       CntW     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CntW-1:0]   BurstMax = CntW'(BURST - 1);
  localparam logic [IdW-1:0]    OwnerRst = IdW'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]  KeyIdx   = IDX_W'(TRANSPARENT_IDX);

  logic [IdW-1:0]  owner_q, owner_d;
  logic [CntW-1:0] burst_q, burst_d;
  // Set only when the previous cycle transferred: after reset or an idle cycle the
  // owner gets no continuation preference, so the search starts at owner+1.
  logic            busy_q, busy_d;

  logic            grant_vld;
  logic [IdW-1:0]  grant_id;
  logic [IdW-1:0]  cand_id;
  int unsigned     cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = owner_q;
    cand      = 0;
    cand_id   = '0;
    if (busy_q && req_valid_i[owner_q] && (burst_q < BurstMax)) begin
      grant_vld = 1'b1;
    end else begin
      // Owner is visited last (k == NUM_REQ), so it wins only as the sole requester.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = 32'(owner_q) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_id = IdW'(cand);
        if (!grant_vld && req_valid_i[cand_id]) begin
          grant_vld = 1'b1;
          grant_id  = cand_id;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    pal_index_o = '0;
    if (grant_vld) begin
      req_ready_o = NUM_REQ'(1) << grant_id;
      pal_index_o = req_index_i[32'(grant_id) * IDX_W +: IDX_W];
    end
  end

  always_comb begin
    owner_d = owner_q;
    burst_d = '0;
    busy_d  = grant_vld;
    if (grant_vld) begin
      if (busy_q && (grant_id == owner_q)) begin
        // Saturate so a sole requester past its burst keeps yielding to new arrivals.
        burst_d = (burst_q < BurstMax) ? burst_q + CntW'(1) : burst_q;
      end else begin
        owner_d = grant_id;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q           <= OwnerRst;
      burst_q           <= '0;
      busy_q            <= 1'b0;
      rsp_valid_o       <= 1'b0;
      rsp_id_o          <= '0;
      rsp_rgb_o         <= '0;
      rsp_transparent_o <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      busy_q      <= busy_d;
      rsp_valid_o <= grant_vld;
      if (grant_vld) begin
        rsp_id_o          <= grant_id;
        rsp_rgb_o         <= {pal_red_i, pal_green_i, pal_blue_i};
        rsp_transparent_o <= (pal_index_o == KeyIdx);
      end
    end
  end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: directed scenarios on BURST=4/1/2 instances plus a
// randomized run of the BURST=4 instance against a grant-history reference model.
module tb_palette_lookup_arbiter;

  localparam int BurstA = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [27:0] index;

  always #5 clk = ~clk;

  logic [3:0]  ready_a, ready_b, ready_c;
  logic [6:0]  pidx_a, pidx_b, pidx_c;
  logic [3:0]  pr_a, pg_a, pb_a, pr_b, pg_b, pb_b, pr_c, pg_c, pb_c;
  logic        rv_a, rv_b, rv_c, rt_a, rt_b, rt_c;
  logic [1:0]  rid_a, rid_b, rid_c;
  logic [11:0] rgb_a, rgb_b, rgb_c;

  int passed = 0;
  int total  = 0;

  function automatic logic [11:0] rom(input logic [6:0] i);
    case (i)
      7'd0:    rom = 12'hF0F;
      7'd2:    rom = 12'hFE7;
      7'd18:   rom = 12'hFFF;
      default: rom = {i[3:0] ^ 4'h5, 1'b1, i[6:4], ~i[3:0]};
    endcase
  endfunction

  assign {pr_a, pg_a, pb_a} = rom(pidx_a);
  assign {pr_b, pg_b, pb_b} = rom(pidx_b);
  assign {pr_c, pg_c, pb_c} = rom(pidx_c);

  palette_lookup_arbiter #(.NUM_REQ(4), .IDX_W(7), .BURST(BurstA), .TRANSPARENT_IDX(0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_index_i(index),
    .req_ready_o(ready_a), .pal_index_o(pidx_a),
    .pal_red_i(pr_a), .pal_green_i(pg_a), .pal_blue_i(pb_a),
    .rsp_valid_o(rv_a), .rsp_id_o(rid_a), .rsp_rgb_o(rgb_a), .rsp_transparent_o(rt_a)
  );

  palette_lookup_arbiter #(.NUM_REQ(4), .IDX_W(7), .BURST(1), .TRANSPARENT_IDX(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_index_i(index),
    .req_ready_o(ready_b), .pal_index_o(pidx_b),
    .pal_red_i(pr_b), .pal_green_i(pg_b), .pal_blue_i(pb_b),
    .rsp_valid_o(rv_b), .rsp_id_o(rid_b), .rsp_rgb_o(rgb_b), .rsp_transparent_o(rt_b)
  );

  palette_lookup_arbiter #(.NUM_REQ(4), .IDX_W(7), .BURST(2), .TRANSPARENT_IDX(0)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_index_i(index),
    .req_ready_o(ready_c), .pal_index_o(pidx_c),
    .pal_red_i(pr_c), .pal_green_i(pg_c), .pal_blue_i(pb_c),
    .rsp_valid_o(rv_c), .rsp_id_o(rid_c), .rsp_rgb_o(rgb_c), .rsp_transparent_o(rt_c)
  );

  // Returns at posedge+1 with reset released and all requests idle.
  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    index = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = '0;
    index = '0;
    #1;
    total++; if (rv_a !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rv_a); else passed++;
    total++; if (rid_a !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", rid_a); else passed++;
    total++; if (rgb_a !== 12'h000) $display("FAIL reset_rsp_rgb: got %h want 000", rgb_a); else passed++;
    total++; if (rt_a !== 1'b0) $display("FAIL reset_rsp_transparent: got %b want 0", rt_a); else passed++;
    total++; if (ready_a !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", ready_a); else passed++;
    total++; if (pidx_a !== 7'd0) $display("FAIL reset_pal_index: got %0d want 0", pidx_a); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    valid = 4'b0001;
    index[6:0] = 7'd2;
    @(negedge clk);
    total++; if (ready_a !== 4'b0001) $display("FAIL basic_ready: got %b want 0001", ready_a); else passed++;
    total++; if (pidx_a !== 7'd2) $display("FAIL basic_pal_index: got %0d want 2", pidx_a); else passed++;
    @(posedge clk);
    #1 valid = '0;
    @(negedge clk);
    total++; if (rv_a !== 1'b1) $display("FAIL basic_rsp_valid: got %b want 1", rv_a); else passed++;
    total++; if (rid_a !== 2'd0) $display("FAIL basic_rsp_id: got %0d want 0", rid_a); else passed++;
    total++; if (rgb_a !== 12'hFE7) $display("FAIL basic_rsp_rgb: got %h want FE7", rgb_a); else passed++;
    total++; if (rt_a !== 1'b0) $display("FAIL basic_rsp_transparent: got %b want 0", rt_a); else passed++;
    @(negedge clk);
    total++; if (rv_a !== 1'b0) $display("FAIL basic_rsp_pulse: got %b want 0", rv_a); else passed++;
    total++; if (rgb_a !== 12'hFE7) $display("FAIL basic_rsp_hold: got %h want FE7", rgb_a); else passed++;
  endtask

  task automatic test_colour_key();
    do_reset();
    valid = 4'b0100;
    index[20:14] = 7'd0;
    @(posedge clk);
    #1 valid = '0;
    @(negedge clk);
    total++; if (rv_a !== 1'b1) $display("FAIL key_rsp_valid: got %b want 1", rv_a); else passed++;
    total++; if (rid_a !== 2'd2) $display("FAIL key_rsp_id: got %0d want 2", rid_a); else passed++;
    total++; if (rgb_a !== 12'hF0F) $display("FAIL key_rsp_rgb: got %h want F0F", rgb_a); else passed++;
    total++; if (rt_a !== 1'b1) $display("FAIL key_transparent: got %b want 1", rt_a); else passed++;
    @(posedge clk);
    #1;
    valid = 4'b0100;
    index[20:14] = 7'd18;
    @(posedge clk);
    #1 valid = '0;
    @(negedge clk);
    total++; if (rgb_a !== 12'hFFF) $display("FAIL key18_rsp_rgb: got %h want FFF", rgb_a); else passed++;
    total++; if (rt_a !== 1'b0) $display("FAIL key18_transparent: got %b want 0", rt_a); else passed++;
  endtask

  task automatic test_burst();
    int exp_seq[10] = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1};
    do_reset();
    valid = 4'b1010;
    index[13:7]  = 7'd5;
    index[27:21] = 7'd9;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (ready_a !== 4'(1 << exp_seq[c]))
        $display("FAIL burst_grant[%0d]: got %b want req %0d", c, ready_a, exp_seq[c]);
      else passed++;
      total++;
      if (pidx_a !== ((exp_seq[c] == 1) ? 7'd5 : 7'd9))
        $display("FAIL burst_pal_index[%0d]: got %0d", c, pidx_a);
      else passed++;
      if (c > 0) begin
        total++;
        if (rv_a !== 1'b1 || rid_a !== 2'(exp_seq[c-1]))
          $display("FAIL burst_rsp[%0d]: got valid %b id %0d want 1/%0d", c, rv_a, rid_a,
                   exp_seq[c-1]);
        else passed++;
      end
      @(posedge clk);
      #1;
    end
    valid = '0;
  endtask

  task automatic test_round_robin();
    logic [6:0] ri[4] = '{7'd11, 7'd22, 7'd33, 7'd0};
    do_reset();
    valid = 4'b1111;
    for (int i = 0; i < 4; i++) index[i*7 +: 7] = ri[i];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (ready_b !== 4'(1 << (c % 4)) || !$onehot(ready_b))
        $display("FAIL rr_grant[%0d]: got %b want req %0d", c, ready_b, c % 4);
      else passed++;
      if (c > 0) begin
        total++;
        if (rv_b !== 1'b1 || rid_b !== 2'((c - 1) % 4) ||
            {rgb_b, rt_b} !== {rom(ri[(c-1)%4]), ri[(c-1)%4] == 7'd0})
          $display("FAIL rr_rsp[%0d]: got v%b id %0d rgb %h t %b", c, rv_b, rid_b, rgb_b, rt_b);
        else passed++;
      end
      @(posedge clk);
      #1;
    end
    valid = '0;
  endtask

  task automatic test_sole();
    int exp_seq[6] = '{2, 2, 2, 0, 0, 2};
    do_reset();
    valid = 4'b0100;
    index[20:14] = 7'd18;
    index[6:0]   = 7'd0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) valid = 4'b0101;
      @(negedge clk);
      total++;
      if (ready_c !== 4'(1 << exp_seq[c]))
        $display("FAIL sole_grant[%0d]: got %b want req %0d", c, ready_c, exp_seq[c]);
      else passed++;
      if (c > 0) begin
        total++;
        if (rv_c !== 1'b1 || rid_c !== 2'(exp_seq[c-1]) ||
            rt_c !== (exp_seq[c-1] == 0) || rgb_c !== ((exp_seq[c-1] == 0) ? 12'hF0F : 12'hFFF))
          $display("FAIL sole_rsp[%0d]: got v%b id %0d rgb %h t %b", c, rv_c, rid_c, rgb_c, rt_c);
        else passed++;
      end
      @(posedge clk);
      #1;
    end
    valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    valid = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rv_a !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", rv_a); else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (rv_a !== 1'b0) $display("FAIL rstmid_async_drop: got %b want 0", rv_a); else passed++;
    valid = 4'b1001;
    #1;
    total++; if (ready_a !== 4'b0001) $display("FAIL rstmid_ready_in_reset: got %b want 0001", ready_a); else passed++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (ready_a !== 4'b0001) $display("FAIL rstmid_first_grant: got %b want 0001", ready_a); else passed++;
    total++; if (rv_a !== 1'b0) $display("FAIL rstmid_no_rsp: got %b want 0", rv_a); else passed++;
    @(posedge clk);
    #1 valid = '0;
    @(negedge clk);
    total++;
    if (rv_a !== 1'b1 || rid_a !== 2'd0)
      $display("FAIL rstmid_rsp: got valid %b id %0d want 1/0", rv_a, rid_a);
    else passed++;
  endtask

  // Reference: the owner keeps the grant only while its uninterrupted run of back-to-back
  // grants is shorter than BURST; otherwise scan owner+1 .. owner for the first pending.
  task automatic test_random();
    bit [3:0]   pending = '0;
    logic [6:0] ridx[4] = '{7'd0, 7'd0, 7'd0, 7'd0};
    int         m_owner = 3;
    int         m_run   = 0;
    bit         m_prev  = 1'b0;
    int         g;
    bit         e_v     = 1'b0;
    int         e_id    = 0;
    logic [11:0] e_rgb  = 12'h000;
    bit         e_t     = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      valid = pending;
      for (int i = 0; i < 4; i++) index[i*7 +: 7] = ridx[i];
      g = -1;
      if (m_prev && pending[m_owner] && m_run < BurstA) g = m_owner;
      else begin
        for (int k = 1; k <= 4; k++) begin
          int cnd;
          cnd = (m_owner + k) % 4;
          if (g < 0 && pending[cnd]) g = cnd;
        end
      end
      @(negedge clk);
      total++;
      if (ready_a !== ((g >= 0) ? 4'(1 << g) : 4'b0000))
        $display("FAIL rand_ready[%0d]: got %b want grant %0d", c, ready_a, g);
      else passed++;
      total++;
      if (pidx_a !== ((g >= 0) ? ridx[g] : 7'd0))
        $display("FAIL rand_pal_index[%0d]: got %0d", c, pidx_a);
      else passed++;
      total++;
      if (rv_a !== e_v || (e_v && (rid_a !== 2'(e_id) || rgb_a !== e_rgb || rt_a !== e_t)))
        $display("FAIL rand_rsp[%0d]: got v%b id %0d rgb %h t %b want v%b id %0d rgb %h t %b",
                 c, rv_a, rid_a, rgb_a, rt_a, e_v, e_id, e_rgb, e_t);
      else passed++;
      @(posedge clk);
      #1;
      if (g >= 0) begin
        e_v   = 1'b1;
        e_id  = g;
        e_rgb = rom(ridx[g]);
        e_t   = (ridx[g] == 7'd0);
        m_run = (m_prev && g == m_owner) ? m_run + 1 : 1;
        m_owner = g;
        m_prev  = 1'b1;
        pending[g] = 1'b0;
      end else begin
        e_v    = 1'b0;
        m_prev = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 0) begin
          pending[i] = 1'b1;
          ridx[i] = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
        end
      end
    end
    valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_colour_key();
    test_burst();
    test_round_robin();
    test_sole();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
